// File: rtl/rx_iq_pkg.sv
// Shared types and constants for the RX IQ elastic buffer.
// No logic of its own; latency and backpressure live in the users of these types.
package rx_iq_pkg;

   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } iq_state_e;

   localparam logic [3:0] RX_IQ_READ_CMD = 4'd4;
   localparam int         DEPTH_LOG2_DEF = 4;
   localparam int         IQ_WIDTH_DEF   = 16;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/iq_fifo_mem.sv
// Register file for packed {I,Q} pairs: synchronous write, asynchronous read.
// Read data is combinational from rd_addr; write lands on the next edge; no backpressure.
module iq_fifo_mem #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 32
) (
   input  logic                  clk_in,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_dat,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_dat
);

   logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_dat;
      end
   end

   assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/rx_iq_buffer.sv
// Elastic buffer from DDC output to the STM32 nibble interface; one untorn pair per read_req.
// Pop latency 1 cycle (outputs held in registers); pairs arriving while full are dropped and counted.
module rx_iq_buffer
   import rx_iq_pkg::*;
#(
   parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
   parameter int IQ_WIDTH    = IQ_WIDTH_DEF,
   parameter int PRIME_LEVEL = 4
) (
   input  logic                  clk_in,
   input  logic                  reset_n,
   input  logic [IQ_WIDTH-1:0]   I_in,
   input  logic [IQ_WIDTH-1:0]   Q_in,
   input  logic                  iq_valid,
   input  logic                  read_req,
   input  logic                  flush,
   input  logic                  ovf_clear,
   output logic [IQ_WIDTH-1:0]   I_out,
   output logic [IQ_WIDTH-1:0]   Q_out,
   output logic                  sample_fresh,
   output logic [DEPTH_LOG2:0]   fifo_level,
   output logic                  overflow,
   output logic                  underrun,
   output logic [7:0]            ovf_count
);

   localparam int                  DEPTH     = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] PRIME_LVL = (DEPTH_LOG2+1)'(PRIME_LEVEL);
   localparam logic [DEPTH_LOG2:0] LVL_ONE   = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);

   iq_state_e             state_q, state_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic [IQ_WIDTH-1:0]   i_out_q, i_out_d;
   logic [IQ_WIDTH-1:0]   q_out_q, q_out_d;
   logic                  fresh_q, fresh_d;
   logic                  ovf_q, ovf_d;
   logic                  und_q, und_d;
   logic [7:0]            cnt_q, cnt_d;

   logic                  full, empty;
   logic                  pop, push, drop, und_evt;
   logic [2*IQ_WIDTH-1:0] rd_dat;

   iq_fifo_mem #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (2*IQ_WIDTH)
   ) u_mem (
      .clk_in  (clk_in),
      .wr_en   (push),
      .wr_addr (wr_ptr_q),
      .wr_dat  ({I_in, Q_in}),
      .rd_addr (rd_ptr_q),
      .rd_dat  (rd_dat)
   );

   // flush suppresses every event in its cycle, including drops and underruns
   always_comb begin
      full    = (level_q == FULL_LVL);
      empty   = (level_q == '0);
      pop     = !flush && read_req && (state_q == ST_RUN) && !empty;
      push    = !flush && iq_valid && (!full || pop);
      drop    = !flush && iq_valid && full && !pop;
      und_evt = !flush && read_req && !pop;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_PRIME;
      end else begin
         state_q <= state_d;
      end
   end

   // priming looks at the post-write level so the 4th write itself arms RUN
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_PRIME;
      end else begin
         case (state_q)
            ST_PRIME: if (level_d >= PRIME_LVL) state_d = ST_RUN;
            ST_RUN:   if (und_evt)              state_d = ST_PRIME;
            default:  state_d = ST_PRIME;
         endcase
      end
   end

   always_comb begin
      i_out_d = i_out_q;
      q_out_d = q_out_q;
      fresh_d = fresh_q;
      if (pop) begin
         i_out_d = rd_dat[2*IQ_WIDTH-1:IQ_WIDTH];
         q_out_d = rd_dat[IQ_WIDTH-1:0];
      end
      if (read_req && !flush) begin
         fresh_d = pop;
      end
   end

   // a same-cycle event beats ovf_clear
   always_comb begin
      ovf_d = ovf_q;
      und_d = und_q;
      cnt_d = cnt_q;
      if (ovf_clear) begin
         ovf_d = 1'b0;
         und_d = 1'b0;
         cnt_d = 8'd0;
      end
      if (drop) begin
         ovf_d = 1'b1;
         cnt_d = ovf_clear ? 8'd1 : sat_inc8(cnt_q);
      end
      if (und_evt) begin
         und_d = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         i_out_q  <= '0;
         q_out_q  <= '0;
         fresh_q  <= 1'b0;
         ovf_q    <= 1'b0;
         und_q    <= 1'b0;
         cnt_q    <= 8'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         i_out_q  <= i_out_d;
         q_out_q  <= q_out_d;
         fresh_q  <= fresh_d;
         ovf_q    <= ovf_d;
         und_q    <= und_d;
         cnt_q    <= cnt_d;
      end
   end

   assign I_out        = i_out_q;
   assign Q_out        = q_out_q;
   assign sample_fresh = fresh_q;
   assign fifo_level   = level_q;
   assign overflow     = ovf_q;
   assign underrun     = und_q;
   assign ovf_count    = cnt_q;

endmodule

// File: tb/tb_rx_iq_buffer.sv
// Bench for rx_iq_buffer: a vector table for the basic read/prime path, then
// scoreboarded sequences for overflow, full-with-pop, drain-to-underrun, flush and reset.
module tb_rx_iq_buffer;

   logic        clk_in = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] I_in = '0;
   logic [15:0] Q_in = '0;
   logic        iq_valid = 1'b0;
   logic        read_req = 1'b0;
   logic        flush = 1'b0;
   logic        ovf_clear = 1'b0;
   logic [15:0] I_out, Q_out;
   logic        sample_fresh;
   logic [4:0]  fifo_level;
   logic        overflow, underrun;
   logic [7:0]  ovf_count;

   int          checks = 0;
   int          errors = 0;
   int          drops  = 0;
   logic [31:0] sb [$];
   logic [15:0] last_i = '0;
   logic [15:0] last_q = '0;

   typedef struct {
      logic        v;
      logic [15:0] i, q;
      logic        rr, fl, oc;
      logic [15:0] ei, eq;
      logic        ef;
      logic [4:0]  el;
      logic        eo, eu;
      logic [7:0]  ec;
   } vec_t;

   vec_t vecs [17];

   rx_iq_buffer dut (
      .clk_in       (clk_in),
      .reset_n      (reset_n),
      .I_in         (I_in),
      .Q_in         (Q_in),
      .iq_valid     (iq_valid),
      .read_req     (read_req),
      .flush        (flush),
      .ovf_clear    (ovf_clear),
      .I_out        (I_out),
      .Q_out        (Q_out),
      .sample_fresh (sample_fresh),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .underrun     (underrun),
      .ovf_count    (ovf_count)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [15:0] ng(input int k);
      return 16'(-k);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [15:0] i, input logic [15:0] q,
                      input logic rr, input logic fl, input logic oc);
      iq_valid  = v;
      I_in      = i;
      Q_in      = q;
      read_req  = rr;
      flush     = fl;
      ovf_clear = oc;
      @(posedge clk_in);
      #1;
      iq_valid  = 1'b0;
      read_req  = 1'b0;
      flush     = 1'b0;
      ovf_clear = 1'b0;
   endtask

   // write with no read in the same cycle; the queue holds exactly the expected FIFO contents
   task automatic wr_pair(input logic [15:0] i, input logic [15:0] q);
      if (sb.size() < 16) sb.push_back({i, q});
      else drops++;
      cyc(1'b1, i, q, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rd_pop(input string tag);
      logic [31:0] e;
      e = sb.pop_front();
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      last_i = e[31:16];
      last_q = e[15:0];
      chk({tag, " I_out"}, I_out, last_i);
      chk({tag, " Q_out"}, Q_out, last_q);
      chk({tag, " fresh"}, 16'(sample_fresh), 16'h1);
      chk({tag, " level"}, 16'(fifo_level), 16'(sb.size()));
   endtask

   initial begin
      // cycle right after reset, priming, first pops, simultaneous write+pop, empty-in-RUN
      vecs[0]  = '{1'b0, 16'd0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd0, 16'd0,  1'b0, 5'd0, 1'b0, 1'b1, 8'd0};
      vecs[1]  = '{1'b0, 16'd0, 16'd0,  1'b0, 1'b0, 1'b1, 16'd0, 16'd0,  1'b0, 5'd0, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{1'b1, 16'd1, ng(1),  1'b0, 1'b0, 1'b0, 16'd0, 16'd0,  1'b0, 5'd1, 1'b0, 1'b0, 8'd0};
      vecs[3]  = '{1'b0, 16'd0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd0, 16'd0,  1'b0, 5'd1, 1'b0, 1'b1, 8'd0};
      vecs[4]  = '{1'b0, 16'd0, 16'd0,  1'b0, 1'b0, 1'b1, 16'd0, 16'd0,  1'b0, 5'd1, 1'b0, 1'b0, 8'd0};
      vecs[5]  = '{1'b1, 16'd2, ng(2),  1'b0, 1'b0, 1'b0, 16'd0, 16'd0,  1'b0, 5'd2, 1'b0, 1'b0, 8'd0};
      vecs[6]  = '{1'b1, 16'd3, ng(3),  1'b0, 1'b0, 1'b0, 16'd0, 16'd0,  1'b0, 5'd3, 1'b0, 1'b0, 8'd0};
      vecs[7]  = '{1'b1, 16'd4, ng(4),  1'b0, 1'b0, 1'b0, 16'd0, 16'd0,  1'b0, 5'd4, 1'b0, 1'b0, 8'd0};
      vecs[8]  = '{1'b0, 16'd0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd1, ng(1),  1'b1, 5'd3, 1'b0, 1'b0, 8'd0};
      vecs[9]  = '{1'b1, 16'd5, ng(5),  1'b1, 1'b0, 1'b0, 16'd2, ng(2),  1'b1, 5'd3, 1'b0, 1'b0, 8'd0};
      vecs[10] = '{1'b0, 16'd0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd3, ng(3),  1'b1, 5'd2, 1'b0, 1'b0, 8'd0};
      vecs[11] = '{1'b0, 16'd0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd4, ng(4),  1'b1, 5'd1, 1'b0, 1'b0, 8'd0};
      vecs[12] = '{1'b0, 16'd0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd5, ng(5),  1'b1, 5'd0, 1'b0, 1'b0, 8'd0};
      vecs[13] = '{1'b1, 16'd6, ng(6),  1'b1, 1'b0, 1'b0, 16'd5, ng(5),  1'b0, 5'd1, 1'b0, 1'b1, 8'd0};
      vecs[14] = '{1'b0, 16'd0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd5, ng(5),  1'b0, 5'd1, 1'b0, 1'b1, 8'd0};
      vecs[15] = '{1'b0, 16'd0, 16'd0,  1'b0, 1'b0, 1'b1, 16'd5, ng(5),  1'b0, 5'd1, 1'b0, 1'b0, 8'd0};
      vecs[16] = '{1'b0, 16'd0, 16'd0,  1'b0, 1'b1, 1'b0, 16'd5, ng(5),  1'b0, 5'd0, 1'b0, 1'b0, 8'd0};

      repeat (3) @(posedge clk_in);
      #1;
      chk("rst I_out", I_out, 16'h0);
      chk("rst Q_out", Q_out, 16'h0);
      chk("rst fresh", 16'(sample_fresh), 16'h0);
      chk("rst level", 16'(fifo_level), 16'h0);
      chk("rst overflow", 16'(overflow), 16'h0);
      chk("rst underrun", 16'(underrun), 16'h0);
      chk("rst ovf_count", 16'(ovf_count), 16'h0);
      reset_n = 1'b1;
      @(posedge clk_in);
      #1;

      for (int n = 0; n < 17; n++) begin
         cyc(vecs[n].v, vecs[n].i, vecs[n].q, vecs[n].rr, vecs[n].fl, vecs[n].oc);
         chk($sformatf("v%0d I_out", n), I_out, vecs[n].ei);
         chk($sformatf("v%0d Q_out", n), Q_out, vecs[n].eq);
         chk($sformatf("v%0d fresh", n), 16'(sample_fresh), 16'(vecs[n].ef));
         chk($sformatf("v%0d level", n), 16'(fifo_level), 16'(vecs[n].el));
         chk($sformatf("v%0d overflow", n), 16'(overflow), 16'(vecs[n].eo));
         chk($sformatf("v%0d underrun", n), 16'(underrun), 16'(vecs[n].eu));
         chk($sformatf("v%0d ovf_count", n), 16'(ovf_count), 16'(vecs[n].ec));
      end
      last_i = 16'd5;
      last_q = ng(5);

      // 20 writes into an empty FIFO: 16 kept, 4 dropped
      sb.delete();
      drops = 0;
      for (int k = 1; k <= 20; k++) wr_pair(16'(k), ng(k));
      chk("ovf level", 16'(fifo_level), 16'd16);
      chk("ovf flag", 16'(overflow), 16'h1);
      chk("ovf count", 16'(ovf_count), 16'(drops));
      chk("ovf count4", 16'(ovf_count), 16'd4);
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("clr flag", 16'(overflow), 16'h0);
      chk("clr count", 16'(ovf_count), 16'h0);

      // full FIFO, write and pop together
      begin
         logic [31:0] e;
         e = sb.pop_front();
         sb.push_back({16'd99, ng(99)});
         cyc(1'b1, 16'd99, ng(99), 1'b1, 1'b0, 1'b0);
         chk("fullwr I_out", I_out, e[31:16]);
         chk("fullwr Q_out", Q_out, e[15:0]);
         chk("fullwr fresh", 16'(sample_fresh), 16'h1);
         chk("fullwr level", 16'(fifo_level), 16'd16);
         chk("fullwr overflow", 16'(overflow), 16'h0);
         chk("fullwr count", 16'(ovf_count), 16'h0);
      end
      while (sb.size() > 0) rd_pop("drain");
      chk("drain tail I", last_i, 16'd99);

      // one entry left in RUN, then a read with nothing behind it
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
      sb.delete();
      for (int k = 1; k <= 4; k++) wr_pair(16'(10 + k), ng(10 + k));
      for (int k = 0; k < 4; k++) rd_pop($sformatf("one%0d", k));
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      chk("empty I_out", I_out, last_i);
      chk("empty Q_out", Q_out, last_q);
      chk("empty fresh", 16'(sample_fresh), 16'h0);
      chk("empty underrun", 16'(underrun), 16'h1);
      chk("empty level", 16'(fifo_level), 16'h0);
      wr_pair(16'd20, ng(20));
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      chk("prime fresh", 16'(sample_fresh), 16'h0);
      chk("prime level", 16'(fifo_level), 16'h1);
      chk("prime I_out", I_out, last_i);

      // level 7, flush racing a write
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
      sb.delete();
      for (int k = 1; k <= 7; k++) wr_pair(16'(30 + k), ng(30 + k));
      chk("pre-flush level", 16'(fifo_level), 16'd7);
      cyc(1'b1, 16'd77, ng(77), 1'b0, 1'b1, 1'b0);
      sb.delete();
      chk("flush level", 16'(fifo_level), 16'h0);
      chk("flush I_out", I_out, last_i);
      chk("flush Q_out", Q_out, last_q);
      chk("flush overflow", 16'(overflow), 16'h0);
      wr_pair(16'd78, ng(78));
      cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      chk("flush prime fresh", 16'(sample_fresh), 16'h0);
      chk("flush prime level", 16'(fifo_level), 16'h1);

      // ovf_clear with a simultaneous drop, then saturation
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
      sb.delete();
      drops = 0;
      for (int k = 1; k <= 19; k++) wr_pair(16'(40 + k), ng(40 + k));
      chk("drop3 count", 16'(ovf_count), 16'd3);
      cyc(1'b1, 16'd88, ng(88), 1'b0, 1'b0, 1'b1);
      chk("clr+drop overflow", 16'(overflow), 16'h1);
      chk("clr+drop count", 16'(ovf_count), 16'h1);
      chk("clr+drop level", 16'(fifo_level), 16'd16);
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("clr2 count", 16'(ovf_count), 16'h0);
      for (int k = 0; k < 260; k++) cyc(1'b1, 16'(k), 16'(k), 1'b0, 1'b0, 1'b0);
      chk("sat count", 16'(ovf_count), 16'd255);
      chk("sat level", 16'(fifo_level), 16'd16);

      // asynchronous reset in the middle of a cycle
      #3 reset_n = 1'b0;
      #1;
      chk("async level", 16'(fifo_level), 16'h0);
      chk("async I_out", I_out, 16'h0);
      chk("async overflow", 16'(overflow), 16'h0);
      chk("async count", 16'(ovf_count), 16'h0);
      #2 reset_n = 1'b1;
      @(posedge clk_in);
      #1;
      sb.delete();
      for (int k = 1; k <= 4; k++) wr_pair(16'(50 + k), ng(50 + k));
      rd_pop("post-rst");
      chk("post-rst first I", last_i, 16'd51);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rx_iq_buffer.md
Name: rx_iq_buffer

Overview:
- Elastic buffer between the DDC decimator output and the STM32 nibble interface on the RX IQ path.
- Captures each decimated I/Q pair on its valid strobe into a small FIFO.
- On each STM32 RX-IQ read request, presents exactly one untorn pair on held output registers, ready for the nibble serializer to latch on the following cycle.
- Reports overflow and underrun so firmware can detect lost or repeated samples.

Parameters:
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 pairs (16).
- IQ_WIDTH, 16, width of each I and Q word, signed two's complement.
- PRIME_LEVEL, 4, fill level required before reads are serviced after reset, flush or underrun; range 1..2**DEPTH_LOG2.

Ports:
- clk_in  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- I_in  in  IQ_WIDTH  decimated I sample.
- Q_in  in  IQ_WIDTH  decimated Q sample.
- iq_valid  in  1  one-cycle strobe; I_in and Q_in are valid.
- read_req  in  1  one-cycle pulse asserted when the STM32 issues an RX-IQ read command (sync plus code 4).
- flush  in  1  synchronous flush; asserted while TX is active.
- ovf_clear  in  1  clears the sticky flags and the overflow counter.
- I_out  out  IQ_WIDTH  held I toward the interface.
- Q_out  out  IQ_WIDTH  held Q toward the interface.
- sample_fresh  out  1  1 = last read_req delivered a new pair; 0 = repeat of a held pair.
- fifo_level  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.
- overflow  out  1  sticky; at least one incoming pair was dropped.
- underrun  out  1  sticky; at least one read_req was served without new data.
- ovf_count  out  8  saturating count of dropped pairs.

Behaviour:
- Reset (async, reset_n=0) forces:
  - pointers and fifo_level = 0, state = PRIME;
  - I_out = 0, Q_out = 0, sample_fresh = 0;
  - overflow = 0, underrun = 0, ovf_count = 0.
- Write path: on iq_valid with the FIFO not full, store {I_in, Q_in} at wr_ptr and increment wr_ptr (wraps modulo depth).
  - iq_valid while full and no pop this cycle: drop the incoming pair, set overflow, increment ovf_count (saturates at 255).
- Read path: acts only on read_req. Pop latency is 1 cycle: I_out/Q_out take the head entry on the same edge that samples read_req, so the interface sees the new pair on the next cycle.
- State machine:
  - PRIME: read_req leaves I_out/Q_out unchanged, clears sample_fresh and sets underrun. Go to RUN when fifo_level >= PRIME_LEVEL, evaluated after this cycle's write.
  - RUN, read_req, FIFO not empty: pop to I_out/Q_out, sample_fresh = 1, rd_ptr increments with wrap.
  - RUN, read_req, FIFO empty: outputs hold, sample_fresh = 0, underrun set, go to PRIME.
- Simultaneous write and pop:
  - Full: the pop frees a slot, the write is accepted, level is unchanged, no overflow.
  - Empty in RUN: no bypass; this counts as underrun and the write is stored.
  - Level stays unchanged whenever a write and a pop both occur.
- flush (synchronous): pointers and level to 0, state to PRIME.
  - I_out, Q_out and the sticky flags are retained.
  - flush has priority over any write or read in the same cycle.
- ovf_clear: clears overflow, underrun and ovf_count. If an overflow or underrun event occurs in the same cycle, the event wins: the flag is set and ovf_count = 1.
- fifo_level is registered and reflects the post-edge occupancy.
- Reset asserted mid-stream discards all content immediately (asynchronous); operation resumes in PRIME on release.

Decomposition:
- Shared package rx_iq_pkg holds:
  - state encoding (PRIME=1'b0, RUN=1'b1);
  - the RX-IQ read command code (4'd4);
  - default DEPTH_LOG2 and IQ_WIDTH constants.
- Sub-module iq_fifo_mem: a 2*IQ_WIDTH-wide, 2**DEPTH_LOG2-deep register file with synchronous write and asynchronous read. Pointer, level, FSM and flag logic stay in rx_iq_buffer.

Test Plan:
- Reset, then write pairs (1,-1),(2,-2),(3,-3),(4,-4), then read_req: state goes to RUN after the 4th write; next cycle I_out=1, Q_out=-1, sample_fresh=1, fifo_level=3.
- Read_req on the cycle after reset, before any writes: I_out/Q_out stay 0, sample_fresh=0, underrun=1, still PRIME.
- Write 20 pairs with no reads: fifo_level=16, overflow=1, ovf_count=4; subsequent reads return pairs 1..16 in order, and pair 17 never appears.
- FIFO full, iq_valid and read_req in the same cycle: level stays 16, overflow stays 0, new pair stored at the tail.
- RUN with 1 entry: two read_reqs. The 1st returns the entry (fresh=1). The 2nd holds the outputs, fresh=0, underrun=1, state PRIME.
- Level 7, flush together with iq_valid: level=0, state PRIME, I_out unchanged; ovf_clear with a simultaneous drop leaves overflow=1, ovf_count=1.
